// File: rtl/rs_ff_bank.sv
// Bank of WIDTH independent SR/JK/D/T flip-flops with parallel load,
// illegal-SR tracking (sticky flag + saturating edge counter) and change detect.
module rs_ff_bank #(
    parameter int unsigned           WIDTH     = 4,
    parameter logic [WIDTH-1:0]      INIT      = '0,
    parameter int unsigned           SR_POLICY = 0,
    parameter int unsigned           CNT_W     = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EN,
    input  logic [1:0]           MODE,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 LOAD,
    input  logic [WIDTH-1:0]     DIN,
    input  logic                 CLR_ERR,
    output logic [WIDTH-1:0]     Q,
    output logic [WIDTH-1:0]     QB,
    output logic                 CHANGED,
    output logic [WIDTH-1:0]     ILL,
    output logic                 ERR,
    output logic [CNT_W-1:0]     ERR_CNT
);

    typedef enum logic [1:0] {
        MODE_SR = 2'b00,
        MODE_JK = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_t;

    mode_t            mode;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] ill_next;
    logic             ill_event;
    logic             changed_r;
    logic [WIDTH-1:0] ill_r;
    logic             err_r;
    logic [CNT_W-1:0] cnt_r;

    assign mode = mode_t'(MODE);

    always_comb begin
        q_next   = q_r;
        ill_next = '0;
        if (LOAD) begin
            q_next = DIN;
        end else if (EN) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                unique case (mode)
                    MODE_SR: begin
                        unique case ({A[i], B[i]})
                            2'b10: q_next[i] = 1'b1;
                            2'b01: q_next[i] = 1'b0;
                            2'b00: q_next[i] = q_r[i];
                            default: begin
                                ill_next[i] = 1'b1;
                                if (SR_POLICY == 0)      q_next[i] = 1'b0;
                                else if (SR_POLICY == 1) q_next[i] = 1'b1;
                                else                     q_next[i] = q_r[i];
                            end
                        endcase
                    end
                    MODE_JK: begin
                        unique case ({A[i], B[i]})
                            2'b10:   q_next[i] = 1'b1;
                            2'b01:   q_next[i] = 1'b0;
                            2'b00:   q_next[i] = q_r[i];
                            default: q_next[i] = ~q_r[i];
                        endcase
                    end
                    MODE_D:  q_next[i] = A[i];
                    default: q_next[i] = q_r[i] ^ A[i];
                endcase
            end
        end
        ill_event = |ill_next;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            q_r       <= INIT;
            changed_r <= 1'b0;
            ill_r     <= '0;
            err_r     <= 1'b0;
            cnt_r     <= '0;
        end else begin
            q_r       <= q_next;
            changed_r <= (q_next != q_r);
            ill_r     <= ill_next;
            // An event in the same cycle as CLR_ERR restarts the count at one.
            if (ill_event) begin
                err_r <= 1'b1;
                if (CLR_ERR)          cnt_r <= CNT_W'(1);
                else if (cnt_r != '1) cnt_r <= cnt_r + CNT_W'(1);
            end else if (CLR_ERR) begin
                err_r <= 1'b0;
                cnt_r <= '0;
            end
        end
    end

    assign Q       = q_r;
    assign QB      = ~q_r;
    assign CHANGED = changed_r;
    assign ILL     = ill_r;
    assign ERR     = err_r;
    assign ERR_CNT = cnt_r;

endmodule

// File: doc/rs_ff_bank.md
Name: rs_ff_bank

Overview:
- Parametrised bank of WIDTH independent flip-flops sharing one clock and one synchronous reset.
- Runtime-selectable mode: SR, JK, D or T.
- Configurable policy for the illegal SR input (S=R=1), sticky error flag with saturating illegal-event counter, parallel load, and change-detect pulse.
- Used as the general storage primitive in the sequential-logic lab designs; replaces single-bit SR flip-flop instances.

Parameters:
- WIDTH, 4, number of flip-flops in the bank (1..32)
- INIT, 0, Q value loaded on reset (WIDTH bits)
- SR_POLICY, 0, S=R=1 action in SR mode: 0 = reset-dominant (Q<=0), 1 = set-dominant (Q<=1), 2 = hold
- CNT_W, 8, width of the illegal-event counter

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  synchronous active-high reset
- EN  in  1  update enable for mode-driven updates
- MODE  in  2  00 = SR, 01 = JK, 10 = D, 11 = T
- A  in  WIDTH  per bit S / J / D / T input
- B  in  WIDTH  per bit R / K input (ignored in D and T modes)
- LOAD  in  1  parallel load strobe
- DIN  in  WIDTH  parallel load data
- CLR_ERR  in  1  clears ERR and ERR_CNT
- Q  out  WIDTH  registered state
- QB  out  WIDTH  registered complement of Q
- CHANGED  out  1  one-cycle pulse, Q changed on the previous edge
- ILL  out  WIDTH  registered mask of bits that saw S=R=1 on the previous edge
- ERR  out  1  sticky illegal-input flag
- ERR_CNT  out  CNT_W  saturating count of edges with any illegal bit

Behaviour:
- Priority on each rising CLK edge: RST > LOAD > EN > hold.
- Reset (RST=1):
  - Q=INIT, QB=~INIT.
  - CHANGED=0, ILL=0, ERR=0, ERR_CNT=0.
  - All other inputs are ignored in that cycle.
  - Reset mid-sequence discards any pending state; no partial updates.
- LOAD=1 (RST=0): Q<=DIN regardless of EN/MODE. ILL<=0. ERR and ERR_CNT are unchanged except by CLR_ERR.
- EN=1, LOAD=0: per bit i, using current MODE (MODE changes take effect on the same edge):
  - SR: A=1,B=0 -> 1; A=0,B=1 -> 0; A=0,B=0 -> hold; A=1,B=1 -> per SR_POLICY, and ILL[i]<=1.
  - JK: 10 -> 1; 01 -> 0; 00 -> hold; 11 -> toggle. JK 11 is legal; no ILL.
  - D: Q[i]<=A[i].
  - T: A[i]=1 toggles Q[i]; A[i]=0 holds.
- EN=0, LOAD=0: Q holds, ILL<=0, CHANGED<=0.
- QB: always exactly ~Q in the same cycle, including after reset and load. There is no one-cycle lag between Q and QB. Q and QB are never equal.
- CHANGED: 1 for exactly one cycle after any edge where the new Q differs from the old Q in any bit; otherwise 0.
- Error logic:
  - An illegal event is one edge where the SR-mode update produces any ILL bit set. It counts once per edge, not per bit.
  - On an event: ERR<=1 and ERR_CNT<=ERR_CNT+1, saturating at 2^CNT_W-1 (no wrap).
  - CLR_ERR alone: ERR<=0, ERR_CNT<=0.
  - CLR_ERR in the same cycle as an event: the event wins, giving ERR=1 and ERR_CNT=1.
  - RST overrides CLR_ERR.
- Latency: all outputs are registered; the response appears one edge after the stimulus. There are no combinational input-to-output paths.

Test Plan (WIDTH=4, INIT=4'b0101, CNT_W=2):
- RST=1 for one edge -> Q=0101, QB=1010, ERR=0, ERR_CNT=0, CHANGED=0. Then EN=0 for 3 edges -> Q stays 0101, CHANGED=0.
- MODE=SR, EN=1, A=0011, B=1100, SR_POLICY=0 -> Q=0011, QB=1100, CHANGED=1 for one cycle. Next edge A=B=0 -> Q holds at 0011, CHANGED=0.
- MODE=SR, A=1001, B=1010, Q=0000, for each SR_POLICY:
  - policy 0 -> Q=0001
  - policy 1 -> Q=1001
  - policy 2 -> Q=0001
  - in every case ILL=1000, ERR=1, ERR_CNT=1.
- Illegal SR held for 5 edges -> ERR_CNT goes 1,2,3,3,3 (saturates). CLR_ERR with a legal input -> ERR=0, ERR_CNT=0. CLR_ERR with an illegal input -> ERR=1, ERR_CNT=1.
- Q=0000:
  - MODE=JK, A=B=1111 for 2 edges -> Q=1111 then 0000, ILL=0.
  - MODE=T, A=0101 -> Q=0101.
  - MODE=D, A=1110 -> Q=1110.
- LOAD=1, DIN=1010 with EN=1, MODE=T, A=1111 -> Q=1010 (load wins). LOAD=1 with RST=1 -> Q=0101 (reset wins).
